viterbi_codec_k3: RTL and testbench
===================================

Name: viterbi_codec_k3

Overview:
Rate-1/2, constraint-length-3 convolutional codec. It combines a convolutional encoder half with a hard-decision Viterbi decoder half that uses register-exchange survivors. The encoder output is intended to pass through an external, possibly corrupting channel and be fed back into the decoder input. The block is the tx/rx core of the Viterbi link; the two halves share only clk and rst.

Parameters:
TB_LEN, 16, survivor register length in symbols = decode latency (range 8..64)
PM_W, 6, path-metric width in bits (saturating, ≥4)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
enc_enable_i  input  1  encoder accepts enc_d_i this cycle
enc_d_i  input  1  information bit
enc_valid_o  output  1  enc_d_o holds a new symbol (1-cycle pulse per accepted bit)
enc_d_o  output  2  code symbol {g0 bit, g1 bit}
dec_enable_i  input  1  decoder accepts dec_d_i this cycle
dec_d_i  input  2  received hard symbol, same bit order as enc_d_o
dec_d_o  output  1  decoded bit
dec_valid_o  output  1  high once TB_LEN symbols have been accepted since reset

Behaviour:
- Code: generators G0=3'b111 (octal 7), G1=3'b101 (octal 5). State s={s1,s0}, where s1 is the most recent past bit. For input b: symbol={b^s1^s0, b^s0}; next state={b,s1}.
- Reset (rst low, async): enc state=0, enc_d_o=2'b00, enc_valid_o=0, dec_d_o=0, dec_valid_o=0, fill counter=0, survivors all 0, PM[0]=0, PM[1..3]=all-ones (max).
- Encoder: on an edge with enc_enable_i=1, enc_d_o<=symbol, state<=next, enc_valid_o<=1. With enable=0, enc_valid_o<=0, and enc_d_o and state hold. Latency is 1 cycle.
- Decoder operates only on edges with dec_enable_i=1. Otherwise all decoder state and outputs hold.
- Branch metric: Hamming distance (0..2) between dec_d_i and the expected branch symbol.
- ACS: next state {b,x} has predecessors {x,0} and {x,1}. Candidate = PM[pred]+BM, saturating at 2^PM_W-1. Pick the smaller candidate; on a tie pick predecessor {x,0}.
- Normalization: compute the minimum of the 4 new metrics, m. Stored PM = new − m, so the best state always holds 0.
- Survivors: surv_new[{b,x}] = {surv[pred][TB_LEN-2:0], b}. The newest bit is at the LSB.
- Output: best = lowest-index state with the new metric equal to m. dec_d_o<=surv_new[best][TB_LEN-1].
- Latency: bit n, accepted at the n-th enabled edge counting from 0, appears on dec_d_o after enabled edge n+TB_LEN-1.
- Fill counter saturates at TB_LEN. dec_valid_o<=1 on the edge where the counter reaches TB_LEN, and it stays 1 until reset.
- Metrics never wrap; saturation plus normalization guarantees no overflow for PM_W≥4.
- Reset mid-stream discards all survivors. Decoding restarts from state 0.

Optional Feature:
VITERBI_ERRCNT_EN: when defined, adds output dec_err_cnt_o [15:0]. It resets to 0 and, on each enabled edge, adds m (the best-path metric increment before normalization), saturating at 16'hFFFF. The result is the estimated count of corrected channel bit errors. When undefined, the port and its logic are absent.

Decomposition:
- Package viterbi_pkg holds:
  - localparams K=3, G0, G1, NSTATES=4
  - typedef state_t (logic [1:0])
  - function branch_sym(state_t s, logic b) returning the 2-bit symbol
- Both halves use branch_sym.
- One sub-module: conv_encoder_k3, which implements the encoder half.
- The decoder ACS/survivor logic stays in the top module.

Test Plan:
1. Assert rst for 3 cycles → enc_d_o=00, enc_valid_o=0, dec_d_o=0, dec_valid_o=0; release with no enables → all outputs hold.
2. Encoder from reset, bits 1,0,1,1 with enable every cycle → enc_d_o=11,10,00,01, and enc_valid_o high for 4 cycles.
3. Error-free loopback, 256 random bits with TB_LEN=16 → dec_valid_o rises after the 16th symbol, dec_d_o reproduces the input delayed 15 enabled edges, 0 mismatches, dec_err_cnt_o=0.
4. Loopback with one flipped bit every 16 symbols → 0 decoded mismatches, and dec_err_cnt_o equals the number of flips.
5. Loopback with dec_enable_i deasserted for 1–5 random cycles between symbols → outputs hold during gaps, and the decoded sequence is identical to scenario 3.
6. 8 consecutive symbols XOR 2'b11 inside a 200-bit stream → no X, no metric wrap (stored PM ≤ 2^PM_W-1), and output matches the input again within 3*TB_LEN symbols after the burst.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, state type and branch-symbol helper for the K=3 rate-1/2 codec.
package viterbi_pkg;

   localparam int unsigned K       = 3;
   localparam logic [K-1:0] G0     = 3'b111;
   localparam logic [K-1:0] G1     = 3'b101;
   localparam int unsigned NSTATES = 4;

   typedef logic [1:0] state_t;

   // Code symbol {g0, g1} emitted when bit b enters a shift register holding state s={s1,s0}.
   function automatic logic [1:0] branch_sym(state_t s, logic b);
      logic [K-1:0] taps;
      taps = {b, s};
      return {^(taps & G0), ^(taps & G1)};
   endfunction

endpackage

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder, one symbol per accepted bit, 1-cycle latency.
module conv_encoder_k3
   import viterbi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       d_i,
   output logic       valid_o,
   output logic [1:0] d_o
);

   state_t     state_q, state_d;
   logic [1:0] sym_q, sym_d;
   logic       valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      sym_d   = sym_q;
      valid_d = 1'b0;
      if (enable_i) begin
         sym_d   = branch_sym(state_q, d_i);
         state_d = {d_i, state_q[1]};
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= '0;
         sym_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sym_q   <= sym_d;
         valid_q <= valid_d;
      end
   end

   assign valid_o = valid_q;
   assign d_o     = sym_q;

endmodule

// File: rtl/viterbi_codec_k3.sv
// K=3 codec: encoder sub-module plus hard-decision register-exchange Viterbi decoder.
// Optional VITERBI_ERRCNT_EN adds dec_err_cnt_o, a saturating sum of per-symbol best-path metric increments.
module viterbi_codec_k3
   import viterbi_pkg::*;
#(
   parameter int unsigned TB_LEN = 16,
   parameter int unsigned PM_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enc_enable_i,
   input  logic        enc_d_i,
   output logic        enc_valid_o,
   output logic [1:0]  enc_d_o,
   input  logic        dec_enable_i,
   input  logic [1:0]  dec_d_i,
   output logic        dec_d_o,
`ifdef VITERBI_ERRCNT_EN
   output logic [15:0] dec_err_cnt_o,
`endif
   output logic        dec_valid_o
);

   localparam int unsigned CNT_W = $clog2(TB_LEN + 1);
   localparam logic [PM_W-1:0] PM_MAX = '1;

   conv_encoder_k3 u_enc (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enc_enable_i),
      .d_i      (enc_d_i),
      .valid_o  (enc_valid_o),
      .d_o      (enc_d_o)
   );

   function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return {x[1] & x[0], x[1] ^ x[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] a, logic [1:0] bm);
      logic [PM_W:0] s;
      s = {1'b0, a} + {{(PM_W-1){1'b0}}, bm};
      return s[PM_W] ? PM_MAX : s[PM_W-1:0];
   endfunction

   logic [PM_W-1:0]   pm_q   [NSTATES];
   logic [PM_W-1:0]   pm_d   [NSTATES];
   logic [PM_W-1:0]   new_pm [NSTATES];
   logic [TB_LEN-1:0] surv_q [NSTATES];
   logic [TB_LEN-1:0] surv_d [NSTATES];
   logic [TB_LEN-1:0] surv_n [NSTATES];
   logic [CNT_W-1:0]  fill_q, fill_d;
   logic              dec_d_q, dec_d_d;
   logic              dec_valid_q, dec_valid_d;
   logic [PM_W-1:0]   m;
   state_t            best;
   state_t            nsv, p0, p1;
   logic [PM_W-1:0]   c0, c1;

   // Add-compare-select over the four states, then pick the lowest-index best state.
   always_comb begin
      m    = PM_MAX;
      best = '0;
      nsv  = '0;
      p0   = '0;
      p1   = '0;
      c0   = '0;
      c1   = '0;
      for (int unsigned ns = 0; ns < NSTATES; ns++) begin
         nsv = state_t'(ns);
         p0  = {nsv[0], 1'b0};
         p1  = {nsv[0], 1'b1};
         c0  = sat_add(pm_q[p0], hamming2(dec_d_i, branch_sym(p0, nsv[1])));
         c1  = sat_add(pm_q[p1], hamming2(dec_d_i, branch_sym(p1, nsv[1])));
         if (c1 < c0) begin
            new_pm[ns] = c1;
            surv_n[ns] = {surv_q[p1][TB_LEN-2:0], nsv[1]};
         end else begin
            new_pm[ns] = c0;
            surv_n[ns] = {surv_q[p0][TB_LEN-2:0], nsv[1]};
         end
      end
      for (int unsigned ns = 0; ns < NSTATES; ns++) begin
         if (new_pm[ns] < m) begin
            m    = new_pm[ns];
            best = state_t'(ns);
         end
      end
   end

   always_comb begin
      pm_d        = pm_q;
      surv_d      = surv_q;
      fill_d      = fill_q;
      dec_d_d     = dec_d_q;
      dec_valid_d = dec_valid_q;
      if (dec_enable_i) begin
         for (int unsigned ns = 0; ns < NSTATES; ns++) begin
            pm_d[ns] = new_pm[ns] - m;
         end
         surv_d  = surv_n;
         dec_d_d = surv_n[best][TB_LEN-1];
         if (fill_q != CNT_W'(TB_LEN)) begin
            fill_d = fill_q + CNT_W'(1);
         end
         if (fill_d == CNT_W'(TB_LEN)) begin
            dec_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned s = 0; s < NSTATES; s++) begin
            pm_q[s]   <= (s == 0) ? '0 : PM_MAX;
            surv_q[s] <= '0;
         end
         fill_q      <= '0;
         dec_d_q     <= 1'b0;
         dec_valid_q <= 1'b0;
      end else begin
         pm_q        <= pm_d;
         surv_q      <= surv_d;
         fill_q      <= fill_d;
         dec_d_q     <= dec_d_d;
         dec_valid_q <= dec_valid_d;
      end
   end

   assign dec_d_o     = dec_d_q;
   assign dec_valid_o = dec_valid_q;

`ifdef VITERBI_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [16:0] err_sum;

   always_comb begin
      err_sum   = {1'b0, err_cnt_q} + 17'(m);
      err_cnt_d = err_cnt_q;
      if (dec_enable_i) begin
         err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign dec_err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_codec_k3.sv
// Self-checking bench for viterbi_codec_k3: random loopback through a bench-side channel model.
module tb_viterbi_codec_k3;

   localparam int unsigned TB_LEN = 16;
   localparam int unsigned PM_W   = 6;
   localparam int NBITS = 256;
   localparam int LAT   = TB_LEN - 1;
   localparam int B_LO  = 80;
   localparam int B_HI  = 87;

   logic        clk = 1'b0;
   logic        rst;
   logic        enc_enable_i;
   logic        enc_d_i;
   logic        enc_valid_o;
   logic [1:0]  enc_d_o;
   logic        dec_enable_i;
   logic [1:0]  dec_d_i;
   logic        dec_d_o;
   logic        dec_valid_o;
`ifdef VITERBI_ERRCNT_EN
   logic [15:0] dec_err_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   logic bits      [NBITS];
   logic clean_dec [NBITS];

   always #5 clk = ~clk;

   viterbi_codec_k3 #(.TB_LEN(TB_LEN), .PM_W(PM_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .enc_enable_i  (enc_enable_i),
      .enc_d_i       (enc_d_i),
      .enc_valid_o   (enc_valid_o),
      .enc_d_o       (enc_d_o),
      .dec_enable_i  (dec_enable_i),
      .dec_d_i       (dec_d_i),
      .dec_d_o       (dec_d_o),
`ifdef VITERBI_ERRCNT_EN
      .dec_err_cnt_o (dec_err_cnt_o),
`endif
      .dec_valid_o   (dec_valid_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      enc_enable_i = 1'b0;
      enc_d_i      = 1'b0;
      dec_enable_i = 1'b0;
      dec_d_i      = 2'b00;
      rst          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One symbol per two cycles: encoder edge, then decoder edge fed through the channel.
   task automatic run_stream(input int mode, input int nsym);
      int         flips;
      int         gap;
      logic       h1, h2, held_d, held_v;
      logic [1:0] exp_sym, chan_err;
      flips = 0;
      do_reset();
      check_val($sformatf("rst_valid_m%0d", mode), 32'(dec_valid_o), 32'(0));
      for (int i = 0; i < nsym; i++) begin
         h1      = (i > 0) ? bits[i-1] : 1'b0;
         h2      = (i > 1) ? bits[i-2] : 1'b0;
         exp_sym = {bits[i] ^ h1 ^ h2, bits[i] ^ h2};
         enc_enable_i = 1'b1;
         enc_d_i      = bits[i];
         @(posedge clk);
         #1;
         check_val($sformatf("enc_sym_m%0d[%0d]", mode, i), 32'(enc_d_o), 32'(exp_sym));
         chan_err = 2'b00;
         if (mode == 1 && (i % 16) == 8) begin
            chan_err = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            flips++;
         end
         if (mode == 3 && i >= B_LO && i <= B_HI) chan_err = 2'b11;
         enc_enable_i = 1'b0;
         dec_enable_i = 1'b1;
         dec_d_i      = enc_d_o ^ chan_err;
         @(posedge clk);
         #1;
         dec_enable_i = 1'b0;
         check_val($sformatf("dec_x_m%0d[%0d]", mode, i), 32'($isunknown(dec_d_o)), 32'(0));
         check_val($sformatf("dec_valid_m%0d[%0d]", mode, i), 32'(dec_valid_o), 32'(i >= LAT));
         if (i >= LAT && (mode != 3 || i < B_LO || i >= B_HI + 3 * int'(TB_LEN)))
            check_val($sformatf("dec_bit_m%0d[%0d]", mode, i - LAT), 32'(dec_d_o), 32'(bits[i-LAT]));
         if (mode == 0) clean_dec[i] = dec_d_o;
         if (mode == 2) begin
            check_val($sformatf("gap_vs_clean[%0d]", i), 32'(dec_d_o), 32'(clean_dec[i]));
            held_d = dec_d_o;
            held_v = dec_valid_o;
            gap    = int'($urandom_range(1, 5));
            for (int g = 0; g < gap; g++) begin
               dec_d_i = 2'($urandom_range(0, 3));
               @(posedge clk);
               #1;
               check_val($sformatf("gap_hold_d[%0d]", i), 32'(dec_d_o), 32'(held_d));
               check_val($sformatf("gap_hold_v[%0d]", i), 32'(dec_valid_o), 32'(held_v));
            end
         end
      end
`ifdef VITERBI_ERRCNT_EN
      if (mode != 3)
         check_val($sformatf("err_cnt_m%0d", mode), 32'(dec_err_cnt_o), 32'(flips));
`endif
   endtask

   initial begin
      logic [1:0] enc_exp [4];
      logic       enc_bits [4];
      rst          = 1'b0;
      enc_enable_i = 1'b0;
      enc_d_i      = 1'b0;
      dec_enable_i = 1'b0;
      dec_d_i      = 2'b00;
      for (int i = 0; i < NBITS; i++) bits[i] = 1'($urandom_range(0, 1));

      // Reset values, then hold with no enables after release.
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_enc_d", 32'(enc_d_o), 32'(0));
      check_val("rst_enc_v", 32'(enc_valid_o), 32'(0));
      check_val("rst_dec_d", 32'(dec_d_o), 32'(0));
      check_val("rst_dec_v", 32'(dec_valid_o), 32'(0));
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("idle_enc_d", 32'(enc_d_o), 32'(0));
      check_val("idle_enc_v", 32'(enc_valid_o), 32'(0));
      check_val("idle_dec_d", 32'(dec_d_o), 32'(0));
      check_val("idle_dec_v", 32'(dec_valid_o), 32'(0));

      // Known encoder vector 1,0,1,1 from state 0.
      enc_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
      enc_exp  = '{2'b11, 2'b10, 2'b00, 2'b01};
      for (int i = 0; i < 4; i++) begin
         enc_enable_i = 1'b1;
         enc_d_i      = enc_bits[i];
         @(posedge clk);
         #1;
         check_val($sformatf("enc_vec[%0d]", i), 32'(enc_d_o), 32'(enc_exp[i]));
         check_val($sformatf("enc_vld[%0d]", i), 32'(enc_valid_o), 32'(1));
      end
      enc_enable_i = 1'b0;
      @(posedge clk);
      #1;
      check_val("enc_vld_drop", 32'(enc_valid_o), 32'(0));
      check_val("enc_d_hold", 32'(enc_d_o), 32'(2'b01));

      run_stream(0, NBITS);
      run_stream(1, NBITS);
      run_stream(2, NBITS);
      run_stream(3, 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
